// File: rtl/ntt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ntt_ctrl
//  Description : Sequencing controller for the Kyber forward NTT over one
//                256-coefficient polynomial. Walks the Cooley-Tukey schedule
//                (7 layers x 128 butterflies), issuing RAM read addresses and
//                the zeta ROM index. It also produces the ntt_cal set strobe
//                and the delayed write-back addresses. No coefficient data
//                passes through this block.
//  Ports       : clk, rst_n         - clock, async active-low reset
//                start              - begin transform (honoured only in IDLE)
//                busy / done        - run in progress / one-cycle completion
//                rd_en, rd_addr_a/b - read strobe, indices j and j+len
//                zeta_idx           - zeta ROM index k
//                cal_set            - butterfly inputs valid this cycle
//                wr_en, wr_addr_a/b - write-back strobe and addresses
//  Revision    : 1.0 - initial release
// ============================================================================
module ntt_ctrl #(
    parameter int MEM_LAT = 1,
    parameter int CAL_LAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       rd_en,
    output logic [7:0] rd_addr_a,
    output logic [7:0] rd_addr_b,
    output logic [6:0] zeta_idx,
    output logic       cal_set,
    output logic       wr_en,
    output logic [7:0] wr_addr_a,
    output logic [7:0] wr_addr_b
);

    // Issue-to-write distance; also the number of DRAIN cycles per layer.
    localparam int c_D  = MEM_LAT + CAL_LAT;
    localparam int c_DW = (c_D > 1) ? $clog2(c_D) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    logic [2:0]      r_l;
    logic [6:0]      r_b;
    logic [c_DW-1:0] r_dcnt;
    logic            r_busy;
    logic            r_done;
    logic            r_rd_en;
    logic [7:0]      r_rd_addr_a;
    logic [7:0]      r_rd_addr_b;
    logic [6:0]      r_zeta_idx;

    // Delay line carrying each issue forward to cal_set and write-back.
    logic [c_D-1:0]  r_pv;
    logic [7:0]      r_pa [c_D];
    logic [7:0]      r_pb [c_D];

    // j = (group * 2*len) + offset, with group = b >> s and offset = b mod len.
    function automatic logic [7:0] f_addr_a(input logic [2:0] l, input logic [6:0] b);
        logic [7:0] bw;
        logic [7:0] len;
        logic [7:0] grp;
        logic [3:0] s;
        bw  = {1'b0, b};
        len = 8'd128 >> l;
        s   = 4'd7 - {1'b0, l};
        grp = bw >> s;
        return (grp << (s + 4'd1)) | (bw & (len - 8'd1));
    endfunction

    function automatic logic [7:0] f_addr_b(input logic [2:0] l, input logic [6:0] b);
        return f_addr_a(l, b) + (8'd128 >> l);
    endfunction

    function automatic logic [6:0] f_zeta(input logic [2:0] l, input logic [6:0] b);
        logic [7:0] bw;
        logic [3:0] s;
        bw = {1'b0, b};
        s  = 4'd7 - {1'b0, l};
        return 7'((8'd1 << l) + (bw >> s));
    endfunction

    // Outputs are registered alongside the counters: whenever (l,b) is
    // loaded, the matching addresses are loaded on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_l         <= 3'd0;
            r_b         <= 7'd0;
            r_dcnt      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_addr_a <= 8'd0;
            r_rd_addr_b <= 8'd0;
            r_zeta_idx  <= 7'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_ISSUE;
                        r_l         <= 3'd0;
                        r_b         <= 7'd0;
                        r_busy      <= 1'b1;
                        r_rd_en     <= 1'b1;
                        r_rd_addr_a <= f_addr_a(3'd0, 7'd0);
                        r_rd_addr_b <= f_addr_b(3'd0, 7'd0);
                        r_zeta_idx  <= f_zeta(3'd0, 7'd0);
                    end
                end
                S_ISSUE: begin
                    if (r_b == 7'd127) begin
                        r_state <= S_DRAIN;
                        r_dcnt  <= '0;
                        r_rd_en <= 1'b0;
                    end else begin
                        r_b         <= r_b + 7'd1;
                        r_rd_addr_a <= f_addr_a(r_l, r_b + 7'd1);
                        r_rd_addr_b <= f_addr_b(r_l, r_b + 7'd1);
                        r_zeta_idx  <= f_zeta(r_l, r_b + 7'd1);
                    end
                end
                S_DRAIN: begin
                    if (r_dcnt == c_DW'(c_D - 1)) begin
                        if (r_l != 3'd6) begin
                            r_state     <= S_ISSUE;
                            r_l         <= r_l + 3'd1;
                            r_b         <= 7'd0;
                            r_rd_en     <= 1'b1;
                            r_rd_addr_a <= f_addr_a(r_l + 3'd1, 7'd0);
                            r_rd_addr_b <= f_addr_b(r_l + 3'd1, 7'd0);
                            r_zeta_idx  <= f_zeta(r_l + 3'd1, 7'd0);
                        end else begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_dcnt <= r_dcnt + c_DW'(1);
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Stage i holds the issue made i+1 cycles earlier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pv <= '0;
            for (int i = 0; i < c_D; i++) begin
                r_pa[i] <= 8'd0;
                r_pb[i] <= 8'd0;
            end
        end else begin
            r_pv[0] <= r_rd_en;
            r_pa[0] <= r_rd_addr_a;
            r_pb[0] <= r_rd_addr_b;
            for (int i = 1; i < c_D; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pa[i] <= r_pa[i-1];
                r_pb[i] <= r_pb[i-1];
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign rd_en     = r_rd_en;
    assign rd_addr_a = r_rd_addr_a;
    assign rd_addr_b = r_rd_addr_b;
    assign zeta_idx  = r_zeta_idx;
    assign cal_set   = r_pv[MEM_LAT-1];
    assign wr_en     = r_pv[c_D-1];
    assign wr_addr_a = r_pa[c_D-1];
    assign wr_addr_b = r_pb[c_D-1];

endmodule
`default_nettype wire

// File: tb/tb_ntt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ntt_ctrl
//  Description : Self-checking bench for ntt_ctrl. A cycle-level schedule
//                model (time since start -> layer/butterfly by division)
//                predicts every output each cycle; literal checkpoints pin
//                the model, and per-run totals/duplicate checks close out
//                each full transform.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ntt_ctrl;

    localparam int MEM_LAT = 1;
    localparam int CAL_LAT = 2;
    localparam int D       = MEM_LAT + CAL_LAT;
    localparam int P       = 128 + D;
    localparam int LAST    = 7 * P;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, rd_en, cal_set, wr_en;
    logic [7:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [6:0] zeta_idx;

    int vectors     = 0;
    int miscompares = 0;

    ntt_ctrl #(.MEM_LAT(MEM_LAT), .CAL_LAT(CAL_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .zeta_idx  (zeta_idx),
        .cal_set   (cal_set),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // m_mt = cycles since start was accepted (1 = first issue cycle).
    logic m_active = 1'b0;
    logic m_virgin = 1'b1;
    int   m_mt     = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_mt     <= 0;
            m_virgin <= 1'b1;
        end else if (m_active) begin
            if (m_mt == LAST + 1) m_active <= 1'b0;
            else                  m_mt     <= m_mt + 1;
        end else if (start) begin
            m_active <= 1'b1;
            m_mt     <= 1;
            m_virgin <= 1'b0;
        end
    end

    // Butterfly issued in schedule cycle x, if any.
    function automatic bit issue_at(input int x, output logic [7:0] a,
                                    output logic [7:0] bb, output logic [6:0] k);
        int l, o, len, grp, j;
        a = 8'd0; bb = 8'd0; k = 7'd0;
        if (x < 1 || x > LAST) return 1'b0;
        l = (x - 1) / P;
        o = (x - 1) % P;
        if (o >= 128) return 1'b0;
        len = 128 >> l;
        grp = o / len;
        j   = grp * 2 * len + o % len;
        a   = 8'(j);
        bb  = 8'(j + len);
        k   = 7'((1 << l) + grp);
        return 1'b1;
    endfunction

    // ---------------- compare process ----------------
    logic       e_rd, e_cal, e_wr, e_busy, e_done, bad;
    logic [7:0] e_a, e_b, e_wa, e_wb, t_a, t_b;
    logic [6:0] e_k, t_k;
    int         rd_cnt, cal_cnt, wr_cnt, dup_cnt, wl;
    logic [255:0] seen [7];

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at mt=%0d: got %0h, expected %0h", name, m_mt, act, exp);
        end
    endtask

    always @(negedge clk) begin
        vectors++;
        bad = 1'b0;
        e_rd = 0; e_cal = 0; e_wr = 0; e_busy = 0; e_done = 0;
        e_a = 0; e_b = 0; e_k = 0; e_wa = 0; e_wb = 0;
        if (!rst_n || m_virgin) begin
            if ({busy, done, rd_en, rd_addr_a, rd_addr_b, zeta_idx, cal_set,
                 wr_en, wr_addr_a, wr_addr_b} !== '0) bad = 1'b1;
        end else if (!m_active) begin
            if ({busy, done, rd_en, cal_set, wr_en} !== 5'b0) bad = 1'b1;
        end else begin
            e_rd   = issue_at(m_mt, e_a, e_b, e_k);
            e_cal  = issue_at(m_mt - MEM_LAT, t_a, t_b, t_k);
            e_wr   = issue_at(m_mt - D, e_wa, e_wb, t_k);
            e_busy = (m_mt <= LAST);
            e_done = (m_mt == LAST + 1);
            if ({busy, done, rd_en, cal_set, wr_en} !== {e_busy, e_done, e_rd, e_cal, e_wr})
                bad = 1'b1;
            if (e_rd && {rd_addr_a, rd_addr_b, zeta_idx} !== {e_a, e_b, e_k}) bad = 1'b1;
            if (e_wr && {wr_addr_a, wr_addr_b} !== {e_wa, e_wb}) bad = 1'b1;
        end
        if (bad) begin
            miscompares++;
            $display("FAIL cycle mt=%0d: got busy=%b done=%b rd=%b a=%0d b=%0d k=%0d cal=%b wr=%b wa=%0d wb=%0d; expected busy=%b done=%b rd=%b a=%0d b=%0d k=%0d cal=%b wr=%b wa=%0d wb=%0d",
                     m_mt, busy, done, rd_en, rd_addr_a, rd_addr_b, zeta_idx, cal_set, wr_en,
                     wr_addr_a, wr_addr_b, e_busy, e_done, e_rd, e_a, e_b, e_k, e_cal, e_wr, e_wa, e_wb);
        end

        if (rst_n && m_active) begin
            // Hand-computed checkpoints.
            case (m_mt)
                1:   lit("c1_rd",   {rd_en, rd_addr_a, rd_addr_b, zeta_idx}, {1'b1, 8'd0,   8'd128, 7'd1});
                2:   lit("c2_cal",  {31'd0, cal_set}, 32'd1);
                4:   lit("c4_wr",   {wr_en, wr_addr_a, wr_addr_b}, {1'b1, 8'd0, 8'd128});
                128: lit("c128_rd", {rd_en, rd_addr_a, rd_addr_b, zeta_idx}, {1'b1, 8'd127, 8'd255, 7'd1});
                130: lit("c130_no_issue", {31'd0, rd_en}, 32'd0);
                132: lit("c132_rd", {rd_en, rd_addr_a, rd_addr_b, zeta_idx}, {1'b1, 8'd0,   8'd64,  7'd2});
                196: lit("c196_rd", {rd_en, rd_addr_a, rd_addr_b, zeta_idx}, {1'b1, 8'd128, 8'd192, 7'd3});
                787: lit("l6b0_rd", {rd_en, rd_addr_a, rd_addr_b, zeta_idx}, {1'b1, 8'd0,   8'd2,   7'd64});
                788: lit("l6b1_rd", {rd_en, rd_addr_a, rd_addr_b, zeta_idx}, {1'b1, 8'd1,   8'd3,   7'd64});
                789: lit("l6b2_rd", {rd_en, rd_addr_a, rd_addr_b, zeta_idx}, {1'b1, 8'd4,   8'd6,   7'd65});
                914: lit("c914_rd", {rd_en, rd_addr_a, rd_addr_b, zeta_idx}, {1'b1, 8'd253, 8'd255, 7'd127});
                917: lit("c917_busy_wr", {30'd0, busy, wr_en}, 32'd3);
                918: lit("c918_done", {30'd0, busy, done}, 32'd1);
                default: ;
            endcase

            // Per-run totals and write-address uniqueness within a layer.
            if (m_mt == 1) begin
                rd_cnt = 0; cal_cnt = 0; wr_cnt = 0; dup_cnt = 0;
                for (int i = 0; i < 7; i++) seen[i] = '0;
            end
            if (rd_en)   rd_cnt++;
            if (cal_set) cal_cnt++;
            if (wr_en) begin
                wr_cnt++;
                wl = (m_mt - D - 1) / P;
                if (m_mt - D - 1 < 0 || wl > 6) dup_cnt++;
                else begin
                    if (seen[wl][wr_addr_a] || seen[wl][wr_addr_b] || wr_addr_a == wr_addr_b)
                        dup_cnt++;
                    seen[wl][wr_addr_a] = 1'b1;
                    seen[wl][wr_addr_b] = 1'b1;
                end
            end
            if (m_mt == LAST + 1) begin
                lit("run_rd_total",  rd_cnt,  896);
                lit("run_cal_total", cal_cnt, 896);
                lit("run_wr_total",  wr_cnt,  896);
                lit("run_dup_addr",  dup_cnt, 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // mode 0: start held high in cycles 50..60; mode 1: random start noise.
    task automatic run_full(input int mode);
        int n;
        start = 1'b1;
        step(1);
        start = 1'b0;
        n = 0;
        while (!(m_active && m_mt == LAST + 1) && n < LAST + 50) begin
            if (mode == 0) start = (m_mt >= 50 && m_mt <= 60);
            else           start = ($urandom_range(0, 3) == 0);
            step(1);
            n++;
        end
        if (!(m_active && m_mt == LAST + 1)) begin
            vectors++;
            miscompares++;
            $display("FAIL run_timeout: got no done within %0d cycles, expected done at %0d", n, LAST + 1);
        end
        // start high in the DONE cycle (ignored) and into the following IDLE cycle.
        start = 1'b1;
        step(1);
    endtask

    task automatic abort_at(input int c);
        int n;
        start = 1'b1;
        step(1);
        start = 1'b0;
        n = 0;
        while (m_mt != c && n < c + 10) begin
            step(1);
            n++;
        end
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            start = 1'b0;
            step(1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        step(5);
        rst_n = 1'b1;
        start = 1'b0;
        step(5);
        run_full(0);
        run_full(1);
        abort_at(300);
        abort_at($urandom_range(100, 900));
        run_full(1);
        start = 1'b0;
        step(5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
